// File: rtl/zero_detect_pkg.sv
// Shared definitions for the pipelined zero-detect block: default parameters,
// per-stage sideband type, and the helpers that size the registered reduce tree.
// Purely elaborate-time; contains no logic of its own.
package zero_detect_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_GROUP = 4;
  localparam int DEF_CNT_W = 16;

  // Per-stage sideband carried next to the tree: item valid and its sign bit.
  typedef struct packed {
    logic vld;
    logic neg;
  } side_t;

  // Smallest L with group^L >= width, i.e. number of registered tree levels.
  function automatic int calc_levels(input int width, input int group);
    int     lv;
    longint span;
    lv   = 0;
    span = 1;
    for (int i = 0; i < 64; i++) begin
      if (span < longint'(width)) begin
        span = span * longint'(group);
        lv   = lv + 1;
      end
    end
    return lv;
  endfunction

  // Bit offset of tree level lvl inside a flattened bus holding levels 0..N,
  // where level 0 is pad_w bits wide and each level shrinks by group.
  function automatic int tree_off(input int pad_w, input int group, input int lvl);
    int off;
    int w;
    off = 0;
    w   = pad_w;
    for (int i = 0; i < 64; i++) begin
      if (i < lvl) begin
        off = off + w;
        w   = w / group;
      end
    end
    return off;
  endfunction

endpackage

// File: rtl/zero_detect_pipe_reduce_stage.sv
// One registered level of the reduce tree: OR (or AND) of each GROUP-bit slice.
// Latency 1 cycle; hold freezes the register so the whole pipe stalls in lockstep.
// Reset loads RST_VAL into every output bit.
module reduce_stage
  import zero_detect_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int GROUP    = 4,
  parameter bit AND_MODE = 1'b0,
  parameter bit RST_VAL  = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic [IN_W-1:0]       din,
  output logic [IN_W/GROUP-1:0] dout
);

  localparam int OUT_W = IN_W / GROUP;

  logic [OUT_W-1:0] dout_d;
  logic [OUT_W-1:0] dout_q;

  // Reduce each GROUP-bit slice to one bit.
  always_comb begin
    dout_d = '0;
    for (int o = 0; o < OUT_W; o++) begin
      if (AND_MODE) dout_d[o] = &din[o*GROUP +: GROUP];
      else          dout_d[o] = |din[o*GROUP +: GROUP];
    end
  end

  // Level register; holds while the pipe is stalled.
  always_ff @(posedge clk) begin
    if (reset)      dout_q <= {OUT_W{RST_VAL}};
    else if (!hold) dout_q <= dout_d;
  end

  assign dout = dout_q;

endmodule

// File: rtl/zero_detect_pipe.sv
// Pipelined zero detect with sign passthrough and saturating zero-result counter.
// Latency LEVELS cycles; whole-pipe stall when out_valid & ~out_ready (in_ready = ~stall).
// Optional all-ones tree and out_ones port under macro ZERO_DETECT_ONES_EN.
module zero_detect_pipe
  import zero_detect_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GROUP = DEF_GROUP,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_zero,
  output logic             out_neg,
  input  logic             clear_count,
`ifdef ZERO_DETECT_ONES_EN
  output logic             out_ones,
`endif
  output logic [CNT_W-1:0] zero_count
);

  localparam int LEVELS = calc_levels(WIDTH, GROUP);
  localparam int PAD_W  = GROUP ** LEVELS;
  localparam int TREE_W = tree_off(PAD_W, GROUP, LEVELS + 1);

  logic              stall;
  side_t             side_q [LEVELS];
  logic [TREE_W-1:0] or_bus;
  logic [PAD_W-1:0]  or_pad;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Zero-pad the operand up to a full power of GROUP for the OR tree.
  always_comb begin
    or_pad              = '0;
    or_pad[WIDTH-1:0]   = in_data;
  end

  assign or_bus[PAD_W-1:0] = or_pad;

`ifdef ZERO_DETECT_ONES_EN
  logic [TREE_W-1:0] and_bus;
  logic [PAD_W-1:0]  and_pad;

  // One-pad the operand so padding never masks an all-ones input.
  always_comb begin
    and_pad            = '1;
    and_pad[WIDTH-1:0] = in_data;
  end

  assign and_bus[PAD_W-1:0] = and_pad;
  assign out_ones           = and_bus[TREE_W-1];
`endif

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int IN_W  = PAD_W / (GROUP ** k);
    localparam int IN_O  = tree_off(PAD_W, GROUP, k);
    localparam int OUT_O = tree_off(PAD_W, GROUP, k + 1);

    // OR level resets to 1 so out_zero reads 0 out of reset.
    reduce_stage #(.IN_W(IN_W), .GROUP(GROUP), .AND_MODE(1'b0), .RST_VAL(1'b1)) u_or (
      .clk   (clk),
      .reset (reset),
      .hold  (stall),
      .din   (or_bus[IN_O +: IN_W]),
      .dout  (or_bus[OUT_O +: IN_W/GROUP])
    );

`ifdef ZERO_DETECT_ONES_EN
    reduce_stage #(.IN_W(IN_W), .GROUP(GROUP), .AND_MODE(1'b1), .RST_VAL(1'b0)) u_and (
      .clk   (clk),
      .reset (reset),
      .hold  (stall),
      .din   (and_bus[IN_O +: IN_W]),
      .dout  (and_bus[OUT_O +: IN_W/GROUP])
    );
`endif
  end

  // Valid and sign shift alongside the tree, frozen together with it on stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LEVELS; i++) side_q[i] <= '0;
    end else if (!stall) begin
      side_q[0] <= '{vld: in_valid, neg: in_data[WIDTH-1]};
      for (int i = 1; i < LEVELS; i++) side_q[i] <= side_q[i-1];
    end
  end

  assign out_valid = side_q[LEVELS-1].vld;
  assign out_neg   = side_q[LEVELS-1].neg;
  assign out_zero  = ~or_bus[TREE_W-1];

  // Saturating count of delivered zero results; clear takes priority.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_count)
      cnt_d = '0;
    else if (out_valid && out_ready && out_zero && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  // Counter register, independent of stall.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_count = cnt_q;

endmodule

// File: tb/tb_zero_detect_pipe.sv
// Scoreboard bench for zero_detect_pipe: directed stimulus pushes hand-computed
// expectations, a negedge monitor pops them on every output handshake and keeps
// a counter model. A second 12-bit/GROUP=2 instance checks the deeper tree.
module tb_zero_detect_pipe;

  localparam int LEVELS = 3;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_zero;
  logic        out_neg;
  logic        clear_count;
  logic [15:0] zero_count;
`ifdef ZERO_DETECT_ONES_EN
  logic        out_ones;
  logic        s_out_ones;
`endif

  logic        s_in_valid;
  logic        s_in_ready;
  logic [11:0] s_in_data;
  logic        s_out_valid;
  logic        s_out_zero;
  logic        s_out_neg;
  logic [7:0]  s_zero_count;

  zero_detect_pipe #(.WIDTH(32), .GROUP(4), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_zero    (out_zero),
    .out_neg     (out_neg),
    .clear_count (clear_count),
`ifdef ZERO_DETECT_ONES_EN
    .out_ones    (out_ones),
`endif
    .zero_count  (zero_count)
  );

  zero_detect_pipe #(.WIDTH(12), .GROUP(2), .CNT_W(8)) dut_s (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (s_in_valid),
    .in_ready    (s_in_ready),
    .in_data     (s_in_data),
    .out_valid   (s_out_valid),
    .out_ready   (1'b1),
    .out_zero    (s_out_zero),
    .out_neg     (s_out_neg),
    .clear_count (1'b0),
`ifdef ZERO_DETECT_ONES_EN
    .out_ones    (s_out_ones),
`endif
    .zero_count  (s_zero_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit z;
    bit n;
    bit o;
    int acc;
    bit chk_lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          total;
  int          bad;
  int          cyc;
  bit          mon_en;
  bit          lat_chk;
  bit          inc;
  logic [15:0] exp_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at cyc %0d", nm, got, exp, cyc);
    end
  endtask

  // Monitor: counter model plus in-order scoreboard pop on output handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("zero_count", {16'h0, zero_count}, {16'h0, exp_cnt});
      if (reset) begin
        sb.delete();
        exp_cnt = 16'h0;
      end else begin
        inc = 1'b0;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output got=valid exp=none at cyc %0d", cyc);
          end else begin
            e = sb.pop_front();
            chk("out_zero", {31'h0, out_zero}, {31'h0, e.z});
            chk("out_neg", {31'h0, out_neg}, {31'h0, e.n});
`ifdef ZERO_DETECT_ONES_EN
            chk("out_ones", {31'h0, out_ones}, {31'h0, e.o});
`endif
            if (e.chk_lat) chk("latency", cyc - e.acc, LEVELS);
            inc = e.z;
          end
        end
        if (clear_count)                    exp_cnt = 16'h0;
        else if (inc && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'h1;
      end
    end
  end

  // Offer one item from posedge+1; push its expectation in the accepting cycle.
  task automatic send(input logic [31:0] d, input bit ez, input bit en, input bit eo);
    bit acc;
    int n;
    acc      = 1'b0;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) sb.push_back('{z: ez, n: en, o: eo, acc: cyc, chk_lat: lat_chk});
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulse();
    clear_count = 1'b1;
    @(posedge clk);
    #1;
    clear_count = 1'b0;
  endtask

  task automatic small_check(input logic [11:0] d, input bit ez, input bit en, input bit eo);
    int start;
    int n;
    s_in_valid = 1'b1;
    s_in_data  = d;
    @(negedge clk);
    chk("s_in_ready", {31'h0, s_in_ready}, 32'd1);
    start = cyc;
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!s_out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("s_latency", cyc - start, 4);
    chk("s_out_zero", {31'h0, s_out_zero}, {31'h0, ez});
    chk("s_out_neg", {31'h0, s_out_neg}, {31'h0, en});
`ifdef ZERO_DETECT_ONES_EN
    chk("s_out_ones", {31'h0, s_out_ones}, {31'h0, eo});
`else
    if (eo) n = n + 0;
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    cyc         = 0;
    mon_en      = 1'b0;
    lat_chk     = 1'b1;
    exp_cnt     = 16'h0;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_data     = 32'h0;
    out_ready   = 1'b1;
    clear_count = 1'b0;
    s_in_valid  = 1'b0;
    s_in_data   = 12'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_out_zero", {31'h0, out_zero}, 32'd0);
    chk("rst_out_neg", {31'h0, out_neg}, 32'd0);
    chk("rst_zero_count", {16'h0, zero_count}, 32'd0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
    chk("rst_s_out_valid", {31'h0, s_out_valid}, 32'd0);
`ifdef ZERO_DETECT_ONES_EN
    chk("rst_out_ones", {31'h0, out_ones}, 32'd0);
`endif
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Single zero result
    send(32'h0000_0000, 1'b1, 1'b0, 1'b0);
    drain();
    @(negedge clk);
    chk("zc_single", {16'h0, zero_count}, 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back stream after a counter clear
    clear_pulse();
    send(32'h0000_0000, 1'b1, 1'b0, 1'b0);
    send(32'h8000_0000, 1'b0, 1'b1, 1'b0);
    send(32'h0001_0000, 1'b0, 1'b0, 1'b0);
    send(32'h0000_0000, 1'b1, 1'b0, 1'b0);
    drain();
    @(negedge clk);
    chk("zc_stream", {16'h0, zero_count}, 32'd2);
    @(posedge clk);
    #1;

    // Stall: outputs frozen, in_ready low, nothing lost or duplicated
    lat_chk = 1'b0;
    fork
      begin
        send(32'h0000_0000, 1'b1, 1'b0, 1'b0);
        send(32'h8000_0001, 1'b0, 1'b1, 1'b0);
        send(32'h0000_0100, 1'b0, 1'b0, 1'b0);
        send(32'h0000_0000, 1'b1, 1'b0, 1'b0);
        send(32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1);
      end
      begin
        int n;
        out_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        for (int i = 0; i < 5; i++) begin
          chk("stall_in_ready", {31'h0, in_ready}, 32'd0);
          chk("stall_out_valid", {31'h0, out_valid}, 32'd1);
          chk("stall_out_zero", {31'h0, out_zero}, 32'd1);
          chk("stall_out_neg", {31'h0, out_neg}, 32'd0);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    lat_chk = 1'b1;

    // Reset with three items in flight
    send(32'h0000_0000, 1'b1, 1'b0, 1'b0);
    send(32'h0000_0000, 1'b1, 1'b0, 1'b0);
    send(32'h0000_0000, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'h0, in_ready}, 32'd1);
    chk("midrst_zero_count", {16'h0, zero_count}, 32'd0);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;

    // Saturation: 65536 zero results leave the counter at all ones
    clear_pulse();
    for (int i = 0; i < 65536; i++) send(32'h0000_0000, 1'b1, 1'b0, 1'b0);
    drain();
    @(negedge clk);
    chk("zc_saturated", {16'h0, zero_count}, 32'h0000_FFFF);
    @(posedge clk);
    #1;

    // Clear coinciding with an incrementing handshake wins
    send(32'h0000_0000, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    clear_count = 1'b1;
    @(negedge clk);
    chk("clr_handshake_valid", {31'h0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    clear_count = 1'b0;
    @(negedge clk);
    chk("zc_clear_wins", {16'h0, zero_count}, 32'd0);
    chk("clr_queue_empty", sb.size(), 0);
    @(posedge clk);
    #1;

    // Deeper tree: WIDTH=12, GROUP=2 gives four levels
    small_check(12'h800, 1'b0, 1'b1, 1'b0);
    small_check(12'hFFF, 1'b0, 1'b1, 1'b1);
    small_check(12'h001, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("s_zero_count", {24'h0, s_zero_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
